// File: rtl/fft_result_buffer.sv
// fft_result_buffer: single-frame buffer between the FFT core and the memory master.
// Fills DEPTH words from the core, pulses fft_done, then serves registered random
// reads until drain_done releases it for the next frame.
// Optional build macro: FFT_BUF_BITREV_EN -- store each word at bit-reverse(wr_ptr) so
// a bit-reversed FFT stream reads back in natural bin order.
module fft_result_buffer #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              fft_done,
  input  logic              sReEn,
  input  logic [ADDR_W-1:0] sampled_address,
  output logic [DATA_W-1:0] sampled_data,
  output logic              sampled_valid,
  input  logic              drain_done,
  output logic              overflow,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] waddr;
  logic              wr_en;
  logic              last_wr;
  logic              rd_en;
  logic              drain_en;

  logic [DATA_W-1:0] mem [DEPTH];

  // Handshake and qualified strobes
  assign in_ready = (state == FILL);
  assign wr_en    = in_valid && in_ready;
  assign last_wr  = wr_en && (wr_ptr == '1);
  assign rd_en    = sReEn && (state == READY);
  assign drain_en = drain_done && (state == READY);

  // Write address: arrival order, or bit-reversed to undo FFT output ordering
`ifdef FFT_BUF_BITREV_EN
  always_comb begin
    waddr = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      waddr[i] = wr_ptr[ADDR_W-1-i];
    end
  end
`else
  assign waddr = wr_ptr;
`endif

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (last_wr)  state_nxt = READY;
      READY:   if (drain_en) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Write pointer; wraps to 0 naturally after the last word of a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        wr_ptr <= '0;
    else if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
  end

  // Frame-complete pulse and completed-frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fft_done  <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      fft_done <= last_wr;
      if (last_wr) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Sticky overflow: a word offered while held; setting beats a same-cycle release
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         overflow <= 1'b0;
    else if (in_valid && !in_ready)  overflow <= 1'b1;
    else if (drain_en)               overflow <= 1'b0;
  end

  // Frame storage write port (contents intentionally not reset)
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= in_data;
  end

  // Registered read port; data holds when no read is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sampled_data  <= '0;
      sampled_valid <= 1'b0;
    end else begin
      sampled_valid <= rd_en;
      if (rd_en) sampled_data <= mem[sampled_address];
    end
  end

endmodule

// File: tb/tb_fft_result_buffer.sv
// Directed bench for fft_result_buffer: a full-size instance for frame behaviour
// and a small-frame instance to reach the 8-bit frame counter wrap quickly.
module tb_fft_result_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        fft_done;
  logic        sReEn;
  logic [8:0]  sampled_address;
  logic [15:0] sampled_data;
  logic        sampled_valid;
  logic        drain_done;
  logic        overflow;
  logic [7:0]  frame_cnt;

  logic        s_rst;
  logic        s_in_valid;
  logic [15:0] s_in_data;
  logic        s_in_ready;
  logic        s_fft_done;
  logic        s_sReEn;
  logic [2:0]  s_addr;
  logic [15:0] s_sampled_data;
  logic        s_sampled_valid;
  logic        s_drain_done;
  logic        s_overflow;
  logic [7:0]  s_frame_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fft_result_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fft_done(fft_done), .sReEn(sReEn), .sampled_address(sampled_address),
    .sampled_data(sampled_data), .sampled_valid(sampled_valid), .drain_done(drain_done),
    .overflow(overflow), .frame_cnt(frame_cnt)
  );

  fft_result_buffer #(.ADDR_W(3), .DATA_W(16)) dut_small (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .fft_done(s_fft_done), .sReEn(s_sReEn), .sampled_address(s_addr),
    .sampled_data(s_sampled_data), .sampled_valid(s_sampled_valid), .drain_done(s_drain_done),
    .overflow(s_overflow), .frame_cnt(s_frame_cnt)
  );

  // Word expected at read address a when the frame was streamed as base+i
  function automatic logic [15:0] exp_word(input logic [8:0] a, input logic [15:0] base);
`ifdef FFT_BUF_BITREV_EN
    logic [8:0] r;
    for (int i = 0; i < 9; i++) r[i] = a[8-i];
    return base + 16'(r);
`else
    return base + 16'(a);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream one full frame base+i; counts fft_done pulses seen before the last word
  task automatic fill_frame(input logic [15:0] base, output int early);
    early = 0;
    for (int i = 0; i < 512; i++) begin
      in_valid = 1'b1;
      in_data  = base + 16'(i);
      tick();
      if (i < 511 && fft_done) early++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_rst = 1'b1;
    tick(); tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (fft_done !== 1'b0) begin bad++; $display("FAIL reset_fft_done got=%b want=0", fft_done); end
    total++; if (sampled_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", sampled_valid); end
    total++; if (sampled_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h want=0000", sampled_data); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
    rst = 1'b0; s_rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_and_read();
    int early;
    logic [15:0] held;
    fill_frame(16'h0000, early);
    total++; if (early !== 0) begin bad++; $display("FAIL fill_early_done got=%0d want=0", early); end
    total++; if (fft_done !== 1'b1) begin bad++; $display("FAIL fill_done_pulse got=%b want=1", fft_done); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b want=0", in_ready); end
    total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL fill_frame_cnt got=%0d want=1", frame_cnt); end
    sReEn = 1'b1; sampled_address = 9'd5;
    tick();
    sReEn = 1'b0;
    total++; if (fft_done !== 1'b0) begin bad++; $display("FAIL done_single_pulse got=%b want=0", fft_done); end
    total++; if (sampled_valid !== 1'b1) begin bad++; $display("FAIL read5_valid got=%b want=1", sampled_valid); end
    total++; if (sampled_data !== exp_word(9'd5, 16'h0)) begin bad++; $display("FAIL read5_data got=%h want=%h", sampled_data, exp_word(9'd5, 16'h0)); end
    held = sampled_data;
    tick();
    total++; if (sampled_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", sampled_valid); end
    total++; if (sampled_data !== held) begin bad++; $display("FAIL idle_hold got=%h want=%h", sampled_data, held); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      sReEn = 1'b1;
      sampled_address = 9'(10 + 101 * k);
      tick();
      total++; if (sampled_valid !== 1'b1 || sampled_data !== exp_word(9'(10 + 101 * k), 16'h0)) begin
        bad++; $display("FAIL b2b_read%0d got=%b/%h want=1/%h", k, sampled_valid, sampled_data, exp_word(9'(10 + 101 * k), 16'h0));
      end
    end
    sReEn = 1'b0;
  endtask

  task automatic test_overflow();
    in_valid = 1'b1; in_data = 16'hdead;
    tick();
    in_valid = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ovf_in_ready got=%b want=0", in_ready); end
    sReEn = 1'b1; sampled_address = 9'd0;
    tick();
    sReEn = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    total++; if (sampled_data !== exp_word(9'd0, 16'h0)) begin bad++; $display("FAIL ovf_mem_kept got=%h want=%h", sampled_data, exp_word(9'd0, 16'h0)); end
    drain_done = 1'b1;
    tick();
    drain_done = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_read_with_drain();
    int early;
    fill_frame(16'h0100, early);
    total++; if (frame_cnt !== 8'd2) begin bad++; $display("FAIL frame2_cnt got=%0d want=2", frame_cnt); end
    sReEn = 1'b1; sampled_address = 9'd0; drain_done = 1'b1;
    tick();
    drain_done = 1'b0;
    total++; if (sampled_valid !== 1'b1) begin bad++; $display("FAIL rd_drain_valid got=%b want=1", sampled_valid); end
    total++; if (sampled_data !== exp_word(9'd0, 16'h0100)) begin bad++; $display("FAIL rd_drain_data got=%h want=%h", sampled_data, exp_word(9'd0, 16'h0100)); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rd_drain_fill got=%b want=1", in_ready); end
    sampled_address = 9'd3;
    tick();
    sReEn = 1'b0;
    total++; if (sampled_valid !== 1'b0) begin bad++; $display("FAIL fill_read_valid got=%b want=0", sampled_valid); end
    total++; if (sampled_data !== exp_word(9'd0, 16'h0100)) begin bad++; $display("FAIL fill_read_hold got=%h want=%h", sampled_data, exp_word(9'd0, 16'h0100)); end
  endtask

  task automatic test_midframe_reset();
    int early;
    int seen = 0;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_data = 16'h0300 + 16'(i);
      tick();
      if (fft_done) seen++;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (frame_cnt !== 8'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL midrst_state got=%0d/%b want=0/1", frame_cnt, in_ready); end
    tick();
    rst = 1'b0;
    tick();
    fill_frame(16'h0200, early);
    total++; if (seen + early !== 0) begin bad++; $display("FAIL midrst_partial_done got=%0d want=0", seen + early); end
    total++; if (fft_done !== 1'b1 || frame_cnt !== 8'd1) begin bad++; $display("FAIL midrst_done got=%b/%0d want=1/1", fft_done, frame_cnt); end
    sReEn = 1'b1; sampled_address = 9'd0;
    tick();
    total++; if (sampled_data !== exp_word(9'd0, 16'h0200)) begin bad++; $display("FAIL midrst_addr0 got=%h want=%h", sampled_data, exp_word(9'd0, 16'h0200)); end
    sampled_address = 9'd299;
    tick();
    sReEn = 1'b0;
    total++; if (sampled_data !== exp_word(9'd299, 16'h0200)) begin bad++; $display("FAIL midrst_addr299 got=%h want=%h", sampled_data, exp_word(9'd299, 16'h0200)); end
  endtask

  task automatic test_overflow_set_wins();
    in_valid = 1'b1; in_data = 16'hbeef; drain_done = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (overflow !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL set_wins got=%b/%b want=1/1", overflow, in_ready); end
    tick();
    drain_done = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL drain_in_fill got=%b want=1", overflow); end
  endtask

  task automatic test_frame_wrap();
    int pulses = 0;
    for (int f = 1; f <= 256; f++) begin
      for (int i = 0; i < 8; i++) begin
        s_in_valid = 1'b1; s_in_data = 16'(i);
        tick();
        if (s_fft_done) pulses++;
      end
      s_in_valid = 1'b0;
      if (f == 1) begin
        total++; if (s_frame_cnt !== 8'd1) begin bad++; $display("FAIL wrap_first got=%0d want=1", s_frame_cnt); end
      end
      if (f == 255) begin
        total++; if (s_frame_cnt !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d want=255", s_frame_cnt); end
      end
      s_drain_done = 1'b1;
      tick();
      s_drain_done = 1'b0;
    end
    total++; if (s_frame_cnt !== 8'd0) begin bad++; $display("FAIL wrap_zero got=%0d want=0", s_frame_cnt); end
    total++; if (pulses !== 256) begin bad++; $display("FAIL wrap_pulses got=%0d want=256", pulses); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; sReEn = 1'b0; sampled_address = '0; drain_done = 1'b0;
    s_rst = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_sReEn = 1'b0; s_addr = '0; s_drain_done = 1'b0;
    test_reset();
    test_fill_and_read();
    test_back_to_back();
    test_overflow();
    test_read_with_drain();
    test_midframe_reset();
    test_overflow_set_wins();
    test_frame_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
